// File: rtl/ip_codma_rd_buffer.sv
// Read-data collection buffer for the CODMA CRC path: gathers up to NWORDS
// read beats into one block and holds it until the CRC stage consumes it.
module ip_codma_rd_buffer #(
    parameter int NWORDS = 8,
    parameter int DATA_W = 32
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic                           start_i,
    input  logic [3:0]                     word_count_i,
    input  logic [DATA_W-1:0]              rdata_i,
    input  logic                           rvalid_i,
    output logic                           rready_o,
    output logic [NWORDS-1:0][DATA_W-1:0]  data_reg_o,
    output logic                           buf_full_o,
    input  logic                           consume_i,
    output logic                           busy_o,
    output logic                           err_o
);

    localparam int         IW        = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [4:0] MAX_COUNT = 5'(NWORDS);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        FULL
    } state_t;

    state_t     state;
    logic [3:0] count;
    logic [3:0] index;
    logic       count_legal;
    logic       last_beat;

    assign count_legal = (word_count_i != 4'd0) && ({1'b0, word_count_i} <= MAX_COUNT);
    assign last_beat   = (index == count - 4'd1);

    assign rready_o = (state == FILL);
    assign busy_o   = (state != IDLE);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state      <= IDLE;
            count      <= 4'd0;
            index      <= 4'd0;
            data_reg_o <= '0;
            buf_full_o <= 1'b0;
            err_o      <= 1'b0;
        end else begin
            err_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        if (count_legal) begin
                            count      <= word_count_i;
                            index      <= 4'd0;
                            data_reg_o <= '0;
                            state      <= FILL;
                        end else begin
                            err_o <= 1'b1;
                        end
                    end
                end
                FILL: begin
                    if (start_i) begin
                        err_o <= 1'b1;
                    end
                    if (rvalid_i) begin
                        data_reg_o[index[IW-1:0]] <= rdata_i;
                        index                     <= index + 4'd1;
                        if (last_beat) begin
                            state      <= FULL;
                            buf_full_o <= 1'b1;
                        end
                    end
                end
                FULL: begin
                    if (consume_i) begin
                        buf_full_o <= 1'b0;
                        // A legal start alongside consume chains straight into the next block.
                        if (start_i && count_legal) begin
                            count      <= word_count_i;
                            index      <= 4'd0;
                            data_reg_o <= '0;
                            state      <= FILL;
                        end else begin
                            state <= IDLE;
                            if (start_i) begin
                                err_o <= 1'b1;
                            end
                        end
                    end else if (start_i) begin
                        err_o <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/ip_codma_rd_buffer.md
IP_CODMA_RD_BUFFER -- requirements
Module: ip_codma_rd_buffer

Interface
REQ-001 SHALL have parameter NWORDS, default 8, number of 32-bit words held in the buffer.
REQ-002 SHALL have parameter DATA_W, default 32, width of one word.
REQ-003 SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_i, input, 1, reset; asynchronous and active-high.
REQ-005 SHALL have port start_i, input, 1, one-cycle request to begin a fill.
REQ-006 SHALL have port word_count_i, input, 4, number of words to collect, sampled with start_i; legal range 1..NWORDS.
REQ-007 SHALL have port rdata_i, input, DATA_W, read-data beat from the memory side.
REQ-008 SHALL have port rvalid_i, input, 1, rdata_i is valid.
REQ-009 SHALL have port rready_o, output, 1, buffer accepts a beat this cycle.
REQ-010 SHALL have port data_reg_o, output, [NWORDS-1:0][DATA_W-1:0], the assembled block fed to the CRC stage.
REQ-011 SHALL have port buf_full_o, output, 1, data_reg_o is complete and stable.
REQ-012 SHALL have port consume_i, input, 1, one-cycle pulse from the CRC stage: block taken.
REQ-013 SHALL have port busy_o, output, 1, high in FILL or FULL.
REQ-014 SHALL have port err_o, output, 1, one-cycle pulse on an illegal request.

Function
REQ-015 SHALL implement FSM states IDLE, FILL and FULL.
REQ-016 SHALL, in IDLE with start_i=1 and word_count_i in 1..NWORDS, latch the count, clear the word index and all of data_reg_o to 0, and enter FILL the next cycle.
REQ-017 SHALL, in IDLE with start_i=1 and word_count_i=0 or >NWORDS, stay in IDLE, leave data_reg_o unchanged and pulse err_o for one cycle.
REQ-018 SHALL drive rready_o=1 only in FILL, combinationally from state.
REQ-019 SHALL, on each cycle with rvalid_i and rready_o both high, register rdata_i into data_reg_o[index] and increment the index.
REQ-020 SHALL fill words in ascending order from index 0; words at and above the latched count remain 0.
REQ-021 SHALL, when the beat at index count-1 is accepted, enter FULL the next cycle with buf_full_o=1, giving 1 cycle latency from the last beat to buf_full_o.
REQ-022 SHALL hold data_reg_o and buf_full_o stable in FULL until consume_i is seen.
REQ-023 SHALL, in FULL with consume_i=1 and start_i=0, return to IDLE the next cycle with buf_full_o=0 and data_reg_o retained.
REQ-024 SHALL, in FULL with consume_i=1 and a legal start_i in the same cycle, go directly to FILL (back-to-back), clearing data_reg_o and latching the new count.
REQ-025 SHALL, on start_i in FILL, or in FULL without consume_i, ignore the request, keep state and data, and pulse err_o.
REQ-026 SHALL ignore consume_i in IDLE and FILL.
REQ-027 SHALL ignore rvalid_i outside FILL, with no data write.
REQ-028 SHALL drive busy_o=1 in FILL and FULL, and 0 in IDLE.

Reset
REQ-029 SHALL, while reset_i=1, asynchronously force state IDLE, index 0, latched count 0, data_reg_o all 0, buf_full_o=0 and err_o=0; rready_o and busy_o are then 0.
REQ-030 SHALL, on reset_i asserted mid-FILL or in FULL, discard the partial or complete block; a new start_i is needed after release.

Verification
REQ-031 SHALL cover a full fill: start_i with count 8, beats 0x11111111..0x88888888 back-to-back -> data_reg_o[0]=0x11111111, [7]=0x88888888; buf_full_o high 1 cycle after the 8th beat; rready_o low in FULL.
REQ-032 SHALL cover a partial fill with stalls: count 3, rvalid_i toggling 1,0,1,0,1 with 0xA,0xB,0xC -> words 0..2 = 0xA,0xB,0xC; words 3..7 = 0; FULL reached after the third accepted beat.
REQ-033 SHALL cover illegal requests: start_i with count 0, then count 9 -> err_o pulses once each, state IDLE, busy_o=0; start_i during FILL -> err_o pulse, fill continues unaffected.
REQ-034 SHALL cover back-to-back blocks: in FULL, consume_i and start_i (count 2) in the same cycle -> next cycle FILL, data_reg_o all 0, buf_full_o=0, no err_o.
REQ-035 SHALL cover reset mid-fill: reset_i asserted after 4 of 8 beats -> immediately buf_full_o=0, rready_o=0, data_reg_o=0; after release, a fresh count-1 fill completes normally.
